// File: rtl/priority_resolver_seq.sv
// priority_resolver_seq: registered PIC priority resolver. It owns the ISR, the
// two-pulse acknowledge sequence, EOI handling and the rotating priority pointer.
// Latency: there is one cycle from an irr/imr/isr change to int_out. The
// irr_clear, vec_valid and isr outputs update on the clock edge after ack.
// Backpressure: none. Each strobe is acted on in the cycle it is seen.
// Optional macro PRI_RES_SPECIAL_MASK_EN adds input smm (special mask mode).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   irr, imr            request and mask vectors (imr 1 = masked)
//   sfnm, aeoi,         mode bits: special fully nested, auto EOI,
//   rotate_aeoi         and rotate on auto EOI
//   ack                 INTA strobe (two per sequence)
//   eoi_*, setpri_valid EOI / set-priority command interface
//   int_out, irr_clear  CPU interrupt line, IRR clear pulse
//   vec_valid, vec_idx  serviced channel report
//   isr, lowest_ptr     in-service register, lowest-priority channel
module priority_resolver_seq #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               sfnm,
  input  logic               aeoi,
  input  logic               rotate_aeoi,
`ifdef PRI_RES_SPECIAL_MASK_EN
  input  logic               smm,
`endif
  input  logic               ack,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [IDX_W-1:0]   eoi_level,
  input  logic               setpri_valid,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic               vec_valid,
  output logic [IDX_W-1:0]   vec_idx,
  output logic [NUM_IRQ-1:0] isr,
  output logic [IDX_W-1:0]   lowest_ptr
);

  typedef enum logic {IDLE, ACK1} state_t;

  state_t             state, state_n;
  logic               win_valid, win_valid_n;
  logic [IDX_W-1:0]   win_idx, win_idx_n;
  logic               spur, spur_n;
  logic [NUM_IRQ-1:0] isr_n, irr_clear_n, set_mask, clr_mask;
  logic [NUM_IRQ-1:0] cand, blk_isr;
  logic [IDX_W-1:0]   ptr_n, vec_idx_n, top_idx, ch;
  logic               vec_valid_n, top_found, blocked, level_ok;

  // The channel at priority rank r (rank 0 = highest) for a given pointer.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] ptr, input int r);
    return IDX_W'((int'(ptr) + 1 + r) % NUM_IRQ);
  endfunction

  assign cand = irr & ~imr;
`ifdef PRI_RES_SPECIAL_MASK_EN
  assign blk_isr = smm ? (isr & ~imr) : isr;
`else
  assign blk_isr = isr;
`endif

  assign level_ok = ({1'b0, eoi_level} < (IDX_W+1)'(NUM_IRQ));

  // Walk the channels in priority order. A request is eligible only if no
  // blocking ISR bit has been passed yet. In sfnm mode the blocking channel
  // itself is still eligible, because the block is applied after the check.
  always_comb begin
    win_valid_n = 1'b0;
    win_idx_n   = '0;
    top_found   = 1'b0;
    top_idx     = '0;
    blocked     = 1'b0;
    ch          = '0;
    for (int r = 0; r < NUM_IRQ; r++) begin
      ch = rot_idx(lowest_ptr, r);
      if (!sfnm && blk_isr[ch]) blocked = 1'b1;
      if (cand[ch] && !blocked && !win_valid_n) begin
        win_valid_n = 1'b1;
        win_idx_n   = ch;
      end
      if (blk_isr[ch]) blocked = 1'b1;
      if (isr[ch] && !top_found) begin
        top_found = 1'b1;
        top_idx   = ch;
      end
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_n     = state;
    spur_n      = spur;
    vec_idx_n   = vec_idx;
    vec_valid_n = 1'b0;
    irr_clear_n = '0;
    set_mask    = '0;
    clr_mask    = '0;
    ptr_n       = lowest_ptr;

    // setpri has the lowest precedence. Later assignments below override it.
    if (setpri_valid && level_ok) ptr_n = eoi_level;

    case (state)
      IDLE: begin
        if (ack) begin
          state_n = ACK1;
          if (win_valid) begin
            set_mask[win_idx]    = 1'b1;
            irr_clear_n[win_idx] = 1'b1;
            vec_idx_n            = win_idx;
            spur_n               = 1'b0;
          end else begin
            vec_idx_n = IDX_W'(NUM_IRQ - 1);
            spur_n    = 1'b1;
          end
        end
      end
      ACK1: begin
        if (ack) begin
          state_n     = IDLE;
          vec_valid_n = 1'b1;
          if (aeoi && !spur) begin
            clr_mask[vec_idx] = 1'b1;
            if (rotate_aeoi) ptr_n = vec_idx;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (eoi_valid) begin
      if (eoi_specific) begin
        if (level_ok) begin
          clr_mask[eoi_level] = 1'b1;
          if (eoi_rotate) ptr_n = eoi_level;
        end
      end else if (top_found) begin
        clr_mask[top_idx] = 1'b1;
        if (eoi_rotate) ptr_n = top_idx;
      end
    end

    // When a bit is set and cleared in the same cycle, the set wins.
    isr_n = (isr & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isr        <= '0;
      lowest_ptr <= IDX_W'(NUM_IRQ - 1);
      win_valid  <= 1'b0;
      win_idx    <= '0;
      irr_clear  <= '0;
      vec_valid  <= 1'b0;
      vec_idx    <= '0;
      spur       <= 1'b0;
    end else begin
      isr        <= isr_n;
      lowest_ptr <= ptr_n;
      win_valid  <= win_valid_n;
      win_idx    <= win_idx_n;
      irr_clear  <= irr_clear_n;
      vec_valid  <= vec_valid_n;
      vec_idx    <= vec_idx_n;
      spur       <= spur_n;
    end
  end

  // int_out drops in the cycle the vector is delivered, even if another
  // winner is already waiting.
  assign int_out = (state == ACK1) | (win_valid & ~vec_valid);

endmodule

// File: tb/tb_priority_resolver_seq.sv
// Testbench for priority_resolver_seq with NUM_IRQ = 8.
// Each table row is driven for one cycle, and the outputs are then compared
// 1 ns after the rising edge.
module tb_priority_resolver_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr, imr;
  logic       sfnm, aeoi, rotate_aeoi, ack;
  logic       eoi_valid, eoi_specific, eoi_rotate, setpri_valid;
  logic [2:0] eoi_level;
  logic       int_out, vec_valid;
  logic [7:0] irr_clear, isr;
  logic [2:0] vec_idx, lowest_ptr;

  int total = 0;
  int bad   = 0;

  priority_resolver_seq #(.NUM_IRQ(8)) dut (
    .clk(clk), .rst_n(rst_n), .irr(irr), .imr(imr), .sfnm(sfnm), .aeoi(aeoi),
    .rotate_aeoi(rotate_aeoi), .ack(ack), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .setpri_valid(setpri_valid), .int_out(int_out), .irr_clear(irr_clear),
    .vec_valid(vec_valid), .vec_idx(vec_idx), .isr(isr), .lowest_ptr(lowest_ptr)
  );

  always #5 clk = ~clk;

  // Control flag bits used in each table row.
  localparam logic [7:0] A  = 8'h01; // ack
  localparam logic [7:0] SF = 8'h02; // sfnm
  localparam logic [7:0] AE = 8'h04; // aeoi
  localparam logic [7:0] RA = 8'h08; // rotate_aeoi
  localparam logic [7:0] EN = 8'h10; // non-specific EOI
  localparam logic [7:0] ES = 8'h20; // specific EOI
  localparam logic [7:0] ER = 8'h40; // eoi_rotate
  localparam logic [7:0] SP = 8'h80; // setpri_valid

  typedef struct {
    logic [7:0] irr;
    logic [7:0] imr;
    logic [7:0] ctl;
    logic [2:0] lvl;
    logic       e_int;
    logic [7:0] e_clr;
    logic       e_vv;
    logic [2:0] e_vidx;
    logic [7:0] e_isr;
    logic [2:0] e_ptr;
  } row_t;

  row_t tbl[$];

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    irr          = r.irr;
    imr          = r.imr;
    ack          = |(r.ctl & A);
    sfnm         = |(r.ctl & SF);
    aeoi         = |(r.ctl & AE);
    rotate_aeoi  = |(r.ctl & RA);
    eoi_valid    = |(r.ctl & (EN | ES));
    eoi_specific = |(r.ctl & ES);
    eoi_rotate   = |(r.ctl & ER);
    setpri_valid = |(r.ctl & SP);
    eoi_level    = r.lvl;
  endtask

  task automatic check_all(input int row, input logic e_int, input logic [7:0] e_clr,
                           input logic e_vv, input logic [2:0] e_vidx,
                           input logic [7:0] e_isr, input logic [2:0] e_ptr);
    chk("int_out",    row, 32'(int_out),    32'(e_int));
    chk("irr_clear",  row, 32'(irr_clear),  32'(e_clr));
    chk("vec_valid",  row, 32'(vec_valid),  32'(e_vv));
    chk("vec_idx",    row, 32'(vec_idx),    32'(e_vidx));
    chk("isr",        row, 32'(isr),        32'(e_isr));
    chk("lowest_ptr", row, 32'(lowest_ptr), 32'(e_ptr));
  endtask

  initial begin
    row_t idle_r;
    // Columns: irr imr ctl lvl | int clr vv vidx isr ptr
    tbl.push_back(row_t'{8'h24, 8'h00, 8'h00,    3'd0, 1, 8'h00, 0, 3'd0, 8'h00, 3'd7}); // 0 win ch2
    tbl.push_back(row_t'{8'h24, 8'h00, A,        3'd0, 1, 8'h04, 0, 3'd2, 8'h04, 3'd7}); // 1 ack1
    tbl.push_back(row_t'{8'h20, 8'h00, 8'h00,    3'd0, 1, 8'h00, 0, 3'd2, 8'h04, 3'd7}); // 2 hold ACK1
    tbl.push_back(row_t'{8'h20, 8'h00, A,        3'd0, 0, 8'h00, 1, 3'd2, 8'h04, 3'd7}); // 3 ack2
    tbl.push_back(row_t'{8'h08, 8'h00, 8'h00,    3'd0, 0, 8'h00, 0, 3'd2, 8'h04, 3'd7}); // 4 ch3 blocked
    tbl.push_back(row_t'{8'h08, 8'h00, EN,       3'd0, 0, 8'h00, 0, 3'd2, 8'h00, 3'd7}); // 5 NS EOI
    tbl.push_back(row_t'{8'h08, 8'h00, 8'h00,    3'd0, 1, 8'h00, 0, 3'd2, 8'h00, 3'd7}); // 6 int next cycle
    tbl.push_back(row_t'{8'h08, 8'h00, A,        3'd0, 1, 8'h08, 0, 3'd3, 8'h08, 3'd7}); // 7
    tbl.push_back(row_t'{8'h00, 8'h00, A,        3'd0, 0, 8'h00, 1, 3'd3, 8'h08, 3'd7}); // 8
    tbl.push_back(row_t'{8'h08, 8'h00, SF,       3'd0, 1, 8'h00, 0, 3'd3, 8'h08, 3'd7}); // 9 sfnm re-entry
    tbl.push_back(row_t'{8'h08, 8'h00, 8'h00,    3'd0, 0, 8'h00, 0, 3'd3, 8'h08, 3'd7}); // 10 normal blocks
    tbl.push_back(row_t'{8'h00, 8'h00, ES|ER,    3'd3, 0, 8'h00, 0, 3'd3, 8'h00, 3'd3}); // 11 spec EOI rot
    tbl.push_back(row_t'{8'h11, 8'h00, 8'h00,    3'd0, 1, 8'h00, 0, 3'd3, 8'h00, 3'd3}); // 12
    tbl.push_back(row_t'{8'h11, 8'h00, A,        3'd0, 1, 8'h10, 0, 3'd4, 8'h10, 3'd3}); // 13 ch4 wins
    tbl.push_back(row_t'{8'h01, 8'h00, A,        3'd0, 0, 8'h00, 1, 3'd4, 8'h10, 3'd3}); // 14
    tbl.push_back(row_t'{8'h01, 8'h00, EN|ER,    3'd0, 0, 8'h00, 0, 3'd4, 8'h00, 3'd4}); // 15 NS EOI rot
    tbl.push_back(row_t'{8'h01, 8'h00, 8'h00,    3'd0, 1, 8'h00, 0, 3'd4, 8'h00, 3'd4}); // 16
    tbl.push_back(row_t'{8'h00, 8'h00, SP,       3'd6, 0, 8'h00, 0, 3'd4, 8'h00, 3'd6}); // 17 setpri
    tbl.push_back(row_t'{8'h80, 8'h00, AE|RA,    3'd0, 1, 8'h00, 0, 3'd4, 8'h00, 3'd6}); // 18
    tbl.push_back(row_t'{8'h80, 8'h00, A|AE|RA,  3'd0, 1, 8'h80, 0, 3'd7, 8'h80, 3'd6}); // 19
    tbl.push_back(row_t'{8'h00, 8'h00, A|AE|RA,  3'd0, 0, 8'h00, 1, 3'd7, 8'h00, 3'd7}); // 20 AEOI rot
    tbl.push_back(row_t'{8'h00, 8'h00, 8'h00,    3'd0, 0, 8'h00, 0, 3'd7, 8'h00, 3'd7}); // 21
    tbl.push_back(row_t'{8'h02, 8'h00, 8'h00,    3'd0, 1, 8'h00, 0, 3'd7, 8'h00, 3'd7}); // 22
    tbl.push_back(row_t'{8'h02, 8'h00, A,        3'd0, 1, 8'h02, 0, 3'd1, 8'h02, 3'd7}); // 23
    tbl.push_back(row_t'{8'h00, 8'h00, A|SP,     3'd5, 0, 8'h00, 1, 3'd1, 8'h02, 3'd5}); // 24
    tbl.push_back(row_t'{8'h00, 8'h00, A|AE|RA,  3'd0, 1, 8'h00, 0, 3'd7, 8'h02, 3'd5}); // 25 spurious
    tbl.push_back(row_t'{8'h00, 8'h00, A|AE|RA,  3'd0, 0, 8'h00, 1, 3'd7, 8'h02, 3'd5}); // 26 no change
    tbl.push_back(row_t'{8'h02, 8'h00, SF,       3'd0, 1, 8'h00, 0, 3'd7, 8'h02, 3'd5}); // 27
    tbl.push_back(row_t'{8'h02, 8'h00, A|SF|ES,  3'd1, 1, 8'h02, 0, 3'd1, 8'h02, 3'd5}); // 28 set beats clr
    tbl.push_back(row_t'{8'h00, 8'h00, A,        3'd0, 0, 8'h00, 1, 3'd1, 8'h02, 3'd5}); // 29
    tbl.push_back(row_t'{8'h00, 8'h00, EN,       3'd0, 0, 8'h00, 0, 3'd1, 8'h00, 3'd5}); // 30
    tbl.push_back(row_t'{8'h0C, 8'h04, 8'h00,    3'd0, 1, 8'h00, 0, 3'd1, 8'h00, 3'd5}); // 31 ch2 masked
    tbl.push_back(row_t'{8'h0C, 8'h04, A,        3'd0, 1, 8'h08, 0, 3'd3, 8'h08, 3'd5}); // 32
    tbl.push_back(row_t'{8'h04, 8'h08, 8'h00,    3'd0, 1, 8'h00, 0, 3'd3, 8'h08, 3'd5}); // 33 imr change in ACK1
    tbl.push_back(row_t'{8'h04, 8'h08, A,        3'd0, 0, 8'h00, 1, 3'd3, 8'h08, 3'd5}); // 34
    tbl.push_back(row_t'{8'h04, 8'h08, 8'h00,    3'd0, 1, 8'h00, 0, 3'd3, 8'h08, 3'd5}); // 35 ch2 outranks ch3

    idle_r = row_t'{8'h00, 8'h00, 8'h00, 3'd0, 0, 8'h00, 0, 3'd0, 8'h00, 3'd7};
    rst_n = 1'b0;
    drive(idle_r);
    repeat (2) @(posedge clk);
    #1;
    check_all(-1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd7);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_all(i, tbl[i].e_int, tbl[i].e_clr, tbl[i].e_vv, tbl[i].e_vidx, tbl[i].e_isr, tbl[i].e_ptr);
    end

    // Take ch2 into service, then assert reset while the FSM is in ACK1.
    drive(row_t'{8'h04, 8'h08, A, 3'd0, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0});
    @(posedge clk);
    #1;
    chk("ack1_int", 100, 32'(int_out), 32'd1);
    chk("ack1_isr", 100, 32'(isr), 32'h0C);
    drive(idle_r);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(101, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd7);
    @(negedge clk);
    rst_n = 1'b1;
    // After reset, the FSM must be in IDLE, so an ack with no request is spurious.
    drive(row_t'{8'h00, 8'h00, A, 3'd0, 0, 8'h00, 0, 3'd0, 8'h00, 3'd0});
    @(posedge clk);
    #1;
    check_all(102, 1'b1, 8'h00, 1'b0, 3'd7, 8'h00, 3'd7);
    drive(idle_r);
    @(posedge clk);
    #1;
    check_all(103, 1'b1, 8'h00, 1'b0, 3'd7, 8'h00, 3'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
